// File: rtl/tx_frame_pkg.sv
// Shared definitions for the transmit framer.
//   frame_state_t : framer FSM states, in on-air byte order
//   CRC16_POLY    : CRC-16/CCITT-FALSE generator polynomial
//   CRC16_INIT    : CRC seed loaded at the start of every frame
//   crc16_byte()  : folds one byte into a CRC value, MSB first
package tx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SYNC_HI  = 3'd2,
    ST_SYNC_LO  = 3'd3,
    ST_LEN      = 3'd4,
    ST_PAYLOAD  = 3'd5,
    ST_CRC_HI   = 3'd6,
    ST_CRC_LO   = 3'd7
  } frame_state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // Byte-wise CRC update: the data byte is XORed into the top of the
  // register, then eight shift/conditional-XOR steps are applied.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_ccitt.sv
// CRC-16/CCITT-FALSE accumulator.
//   clk  : system clock
//   rst  : asynchronous active-low reset (register returns to CRC16_INIT)
//   init : reload the seed (takes priority over en)
//   en   : fold data into the running CRC
//   data : byte to fold in
//   crc  : current CRC value (registered)
module crc16_ccitt
  import tx_frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  // NOTE: sequential state is always written with non-blocking (<=)
  // assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc <= CRC16_INIT;
    end else if (init) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_byte(crc, data);
    end
  end

endmodule

// File: rtl/tx_framer.sv
// Byte-oriented transmit framer. Emits, as a ready/valid byte stream:
//   PREAMBLE_LEN x PREAMBLE_BYTE, SYNC_WORD (high byte first), N,
//   N payload bytes streamed through from the input, CRC-16 (high first).
// Ports:
//   clk, rst               : clock, asynchronous active-low reset
//   hdr_valid/hdr_len/hdr_ready : frame request carrying payload length N
//   in_valid/in_data/in_ready   : payload byte stream
//   out_valid/out_data/out_ready: framed output stream (single register stage)
//   busy                   : frame in progress, including the pending last byte
module tx_framer
  import tx_frame_pkg::*;
#(
  parameter int          PREAMBLE_LEN  = 4,
  parameter logic [7:0]  PREAMBLE_BYTE = 8'h55,
  parameter logic [15:0] SYNC_WORD     = 16'h2DD4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hdr_valid,
  input  logic [7:0] hdr_len,
  output logic       hdr_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);

  frame_state_t state_q, state_d;
  logic [7:0]   len_q, len_d;
  logic [7:0]   cnt_q, cnt_d;   // low nibble counts preamble, full byte counts payload
  logic         run_q;          // holds hdr_ready low while reset is asserted
  logic         free;
  logic         load;
  logic [7:0]   load_byte;
  logic         crc_init;
  logic         crc_en;
  logic [15:0]  crc;

  // The output register can take a new byte when empty or being drained.
  assign free = !out_valid || out_ready;

  // In IDLE out_valid can only be high while the CRC_LO byte is pending.
  assign busy = (state_q != ST_IDLE) || out_valid;

  crc16_ccitt u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (crc_en),
    .data (in_data),
    .crc  (crc)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise a
    // path through the case that skips it would infer a latch.
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    load_byte = 8'h00;
    hdr_ready = 1'b0;
    in_ready  = 1'b0;
    crc_init  = 1'b0;
    crc_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        hdr_ready = run_q && free;
        if (hdr_valid && hdr_ready) begin
          len_d    = hdr_len;
          cnt_d    = 8'd0;
          crc_init = 1'b1;
          state_d  = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        if (free) begin
          load      = 1'b1;
          load_byte = PREAMBLE_BYTE;
          if (cnt_q[3:0] == PRE_LAST) begin
            cnt_d   = 8'd0;
            state_d = ST_SYNC_HI;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_SYNC_HI: begin
        if (free) begin
          load      = 1'b1;
          load_byte = SYNC_WORD[15:8];
          state_d   = ST_SYNC_LO;
        end
      end
      ST_SYNC_LO: begin
        if (free) begin
          load      = 1'b1;
          load_byte = SYNC_WORD[7:0];
          state_d   = ST_LEN;
        end
      end
      ST_LEN: begin
        if (free) begin
          load      = 1'b1;
          load_byte = len_q;
          state_d   = (len_q == 8'd0) ? ST_CRC_HI : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        in_ready = free;
        if (in_valid && free) begin
          load      = 1'b1;
          load_byte = in_data;
          crc_en    = 1'b1;
          if (cnt_q == len_q - 8'd1) begin
            cnt_d   = 8'd0;
            state_d = ST_CRC_HI;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_CRC_HI: begin
        if (free) begin
          load      = 1'b1;
          load_byte = crc[15:8];
          state_d   = ST_CRC_LO;
        end
      end
      ST_CRC_LO: begin
        if (free) begin
          load      = 1'b1;
          load_byte = crc[7:0];
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      len_q     <= 8'd0;
      cnt_q     <= 8'd0;
      run_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
      // out_data is left alone when the register drains, so it only
      // changes on a load, which keeps it stable under back-pressure.
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_byte;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tx_framer.sv
// Scoreboard bench for tx_framer: drivers push expected bytes into exp_q,
// a monitor pops and compares on every output handshake.
module tb_tx_framer;

  logic       clk;
  logic       rst;
  logic       hdr_valid;
  logic [7:0] hdr_len;
  logic       hdr_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;

  tx_framer #(
    .PREAMBLE_LEN  (4),
    .PREAMBLE_BYTE (8'h55),
    .SYNC_WORD     (16'h2DD4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hdr_valid (hdr_valid),
    .hdr_len   (hdr_len),
    .hdr_ready (hdr_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         hs_cyc[$];
  int         hdr_cyc[$];
  bit         rand_ready = 0;
  bit         in_ready_seen = 0;
  bit         stall_q = 0;
  logic [7:0] stall_data = 8'h00;
  logic [7:0] pl_a[$];
  logic [7:0] pl_b[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bit-serial reference CRC-16/CCITT-FALSE.
  function automatic logic [15:0] crc_model(input logic [7:0] b[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (b[i]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ b[i][k];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  // Monitor: all sampling happens on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", 32'(out_data), 32'(stall_data));
        end
        if (in_ready) in_ready_seen = 1'b1;
        if (hdr_valid && hdr_ready) hdr_cyc.push_back(cyc);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("extra_byte", 32'(exp_q.size()), 32'd1);
          else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
          hs_cyc.push_back(cyc);
        end
        stall_q    = out_valid && !out_ready;
        stall_data = out_data;
      end
    end
  end

  // Downstream ready: always 1, or random when rand_ready is set.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_hdr(input logic [7:0] n);
    int t;
    t = 0;
    hdr_valid = 1'b1;
    hdr_len   = n;
    forever begin
      @(negedge clk);
      if (hdr_ready) break;
      t++;
      if (t > 2000) begin
        check("hdr_timeout", 32'(t), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    hdr_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [7:0] b[$], input bit gaps);
    int t;
    foreach (b[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = b[i];
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        t++;
        if (t > 2000) begin
          check("in_timeout", 32'(t), 32'd0);
          break;
        end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    check({name, "_busy_end"}, 32'(busy), 32'd0);
    check({name, "_valid_end"}, 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] crc_b;
    rst       = 1'b0;
    hdr_valid = 1'b0;
    hdr_len   = 8'h00;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_hdr_ready", 32'(hdr_ready), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: N=9 "123456789", out_ready=1, gap-free.
    pl_a = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    hs_cyc.delete();
    hdr_cyc.delete();
    exp_q = {8'h55, 8'h55, 8'h55, 8'h55, 8'h2D, 8'hD4, 8'h09,
             8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h29, 8'hB1};
    send_hdr(8'd9);
    check("t1_busy_after_hdr", 32'(busy), 32'd1);
    send_payload(pl_a, 1'b0);
    wait_drain("t1");
    check("t1_nbytes", 32'(hs_cyc.size()), 32'd18);
    if (hs_cyc.size() == 18 && hdr_cyc.size() == 1) begin
      check("t1_first_latency", 32'(hs_cyc[0] - hdr_cyc[0]), 32'd2);
      check("t1_gap_free", 32'(hs_cyc[17] - hs_cyc[0]), 32'd17);
    end

    // 2: N=0 frame, in_ready must never assert.
    in_ready_seen = 1'b0;
    exp_q = {8'h55, 8'h55, 8'h55, 8'h55, 8'h2D, 8'hD4, 8'h00, 8'hFF, 8'hFF};
    send_hdr(8'd0);
    wait_drain("t2");
    check("t2_in_ready_never", 32'(in_ready_seen), 32'd0);

    // 3: N=9 with random out_ready and payload gaps.
    rand_ready = 1'b1;
    exp_q = {8'h55, 8'h55, 8'h55, 8'h55, 8'h2D, 8'hD4, 8'h09,
             8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h29, 8'hB1};
    send_hdr(8'd9);
    send_payload(pl_a, 1'b1);
    wait_drain("t3");
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 4: back-to-back headers, N=1 {00} then N=2 {A5,5A}.
    pl_b  = {8'hA5, 8'h5A};
    crc_b = crc_model(pl_b);
    hs_cyc.delete();
    hdr_cyc.delete();
    exp_q = {8'h55, 8'h55, 8'h55, 8'h55, 8'h2D, 8'hD4, 8'h01, 8'h00, 8'hE1, 8'hF0,
             8'h55, 8'h55, 8'h55, 8'h55, 8'h2D, 8'hD4, 8'h02, 8'hA5, 8'h5A,
             crc_b[15:8], crc_b[7:0]};
    pl_a = {8'h00, 8'hA5, 8'h5A};
    fork
      begin
        send_hdr(8'd1);
        send_hdr(8'd2);
      end
      send_payload(pl_a, 1'b0);
    join
    wait_drain("t4");
    check("t4_nbytes", 32'(hs_cyc.size()), 32'd21);
    if (hs_cyc.size() == 21 && hdr_cyc.size() == 2) begin
      check("t4_hdr2_with_crc_lo", 32'(hdr_cyc[1]), 32'(hs_cyc[9]));
      check("t4_one_bubble", 32'(hs_cyc[10] - hs_cyc[9]), 32'd2);
    end

    // 5: reset during payload, then a clean N=0 frame.
    pl_a = {8'h31, 8'h32, 8'h33};
    exp_q = {8'h55, 8'h55, 8'h55, 8'h55, 8'h2D, 8'hD4, 8'h09,
             8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h29, 8'hB1};
    send_hdr(8'd9);
    send_payload(pl_a, 1'b0);
    check("t5_busy_mid", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check("t5_rst_out_data", 32'(out_data), 32'd0);
    check("t5_rst_hdr_ready", 32'(hdr_ready), 32'd0);
    check("t5_rst_in_ready", 32'(in_ready), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t5_idle_after_rst", 32'(out_valid), 32'd0);
    in_ready_seen = 1'b0;
    exp_q = {8'h55, 8'h55, 8'h55, 8'h55, 8'h2D, 8'hD4, 8'h00, 8'hFF, 8'hFF};
    send_hdr(8'd0);
    wait_drain("t5");
    check("t5_in_ready_never", 32'(in_ready_seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tx_framer.md
# tx_framer

Byte-oriented transmit framer in the TX path, directly upstream of the 8-to-2 `stream_resizer` that feeds the symbol mapper. It accepts a frame length on a header handshake and the payload bytes on a data handshake. It emits a complete over-the-air frame as a ready/valid byte stream: preamble, sync word, length byte, payload, then CRC-16. Payload is streamed through without buffering.

## Interface
- `PREAMBLE_LEN`, 4, number of preamble bytes (1..15).
- `PREAMBLE_BYTE`, 8'h55, preamble byte value.
- `SYNC_WORD`, 16'h2DD4, sync word, sent high byte first.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `hdr_valid`  in  1  frame request present.
- `hdr_len`  in  8  payload byte count N (0..255).
- `hdr_ready`  out  1  header accepted when `hdr_valid && hdr_ready`.
- `in_valid`  in  1  payload byte present.
- `in_data`  in  8  payload byte.
- `in_ready`  out  1  payload byte accepted when `in_valid && in_ready`.
- `out_valid`  out  1  output byte present.
- `out_data`  out  8  output byte.
- `out_ready`  in  1  downstream accepts.
- `busy`  out  1  high from header acceptance until the last CRC byte is accepted.

## Operation
- Frame on the wire: PREAMBLE_LEN × PREAMBLE_BYTE, SYNC_WORD[15:8], SYNC_WORD[7:0], N, N payload bytes, CRC[15:8], CRC[7:0]. Total is PREAMBLE_LEN+5+N bytes.
- CRC: CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR). It covers payload bytes only. It is re-initialised to 0xFFFF on header acceptance.
- Output register: one stage holding `out_valid`/`out_data`. It may load when `free = !out_valid || out_ready`.
- States: IDLE, PREAMBLE, SYNC_HI, SYNC_LO, LEN, PAYLOAD, CRC_HI, CRC_LO.
- Each state loads its byte into the output register on a cycle where `free` holds, then advances.
- IDLE: `hdr_ready = free`. On header accept, latch N, clear the byte counter, go to PREAMBLE. Nothing is loaded that cycle.
- PREAMBLE: load PREAMBLE_BYTE and increment the counter. After the PREAMBLE_LEN-th load, go to SYNC_HI.
- SYNC_HI → SYNC_LO → LEN: load the sync bytes, then N.
- After LEN: go to PAYLOAD if N≠0, else CRC_HI.
- PAYLOAD: `in_ready = free`. Each accepted byte goes to the output register and is folded into the CRC. After the N-th byte, go to CRC_HI.
- CRC_HI: load CRC[15:8]. CRC_LO: load CRC[7:0], then go to IDLE.
- `hdr_ready` is 0 outside IDLE. `in_ready` is 0 outside PAYLOAD.
- `busy` = state≠IDLE, or `out_valid` high with the last CRC byte still pending.
- Back-pressure: while `out_valid && !out_ready`, `out_data` is held stable. Payload bytes are never dropped or duplicated.
- `in_valid` low in PAYLOAD stalls the frame. The output goes idle (`out_valid`=0) and the frame resumes when data arrives; there is no timeout.
- Reset (any time, including mid-frame): state IDLE, counters 0, CRC 0xFFFF, `out_valid`=0, `out_data`=0, `hdr_ready`=0, `in_ready`=0, `busy`=0. A partial frame is abandoned and is not completed after reset.

## Timing
- Header accept at edge k: the first preamble byte is valid after edge k+1.
- Payload latency: a byte accepted at edge k appears on `out_data` after edge k.
- With `out_ready` held at 1 and no payload stalls, the frame streams one byte per cycle, gap-free.
- Back-to-back frames:
  - The next header can be accepted in the cycle the CRC_LO byte is being accepted, since `free` is true then.
  - There is a one-cycle bubble between frames (the IDLE acceptance cycle).
- `hdr_ready` and `in_ready` depend combinationally on `out_ready`. No other combinational input-to-output paths exist.

## Structure
- Package `tx_frame_pkg`:
  - state enum `frame_state_t`.
  - `CRC16_POLY` = 16'h1021.
  - `CRC16_INIT` = 16'hFFFF.
  - function `crc16_byte(crc, byte)` (bytewise, MSB-first).
- Sub-module `crc16_ccitt`, which holds the CRC register:
  - `init` strobe, `en` strobe, 8-bit data input, 16-bit CRC output.
  - Same clock and reset as the parent; resets to 0xFFFF.
- Top module: FSM, byte counter (4 bits preamble / 8 bits payload), output register.

## Test plan
- Defaults, N=9, payload "123456789" (0x31..0x39), `out_ready`=1 → 18 bytes: 55 55 55 55 2D D4 09 31..39 29 B1. `busy` deasserts after the last byte.
- N=0, `out_ready`=1 → 55 55 55 55 2D D4 00 FF FF. `in_ready` never asserts.
- N=9 as above with random `out_ready` and random `in_valid` gaps → identical 18-byte sequence. `out_data` stays stable during every stall.
- Two headers queued (N=1 with byte 0x00, then N=2) → two complete frames. The first frame's CRC is E1 F0. Exactly one idle cycle separates the frames.
- Reset asserted during the payload of an N=9 frame → all outputs 0 immediately. After release, a new N=0 frame is emitted correctly with CRC FF FF.
